// File: rtl/frame_threshold_ctrl.sv
// Frame-synchronous threshold controller: debounced grade keys, per-frame motion count,
// grade/threshold committed only at frame boundaries. Optional auto grading: FRAME_AUTO_THRESH_EN.

module frame_key_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

    logic            sync0_q, sync0_d;
    logic            sync1_q, sync1_d;
    logic            stable_q, stable_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            press_q, press_d;

    always_comb begin
        sync0_d  = key_n;
        sync1_d  = sync0_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync1_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
            stable_d = sync1_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DB_W'(1);
        end
        // Only a released-to-pressed transition of the stable level is a request.
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q  <= 1'b1;
            sync1_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync0_q  <= sync0_d;
            sync1_q  <= sync1_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;
endmodule

module frame_threshold_ctrl #(
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int CNT_W        = 20,
    parameter int GRADE_INIT   = 2,
    parameter int HI_MARK      = 20000,
    parameter int LO_MARK      = 2000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_add_n,
    input  logic             key_sub_n,
    input  logic             per_frame_vsync,
    input  logic             per_frame_clken,
    input  logic             per_img_motion,
    input  logic             auto_en,
    output logic [3:0]       frame_grade,
    output logic [7:0]       frame_threshold,
    output logic [CNT_W-1:0] motion_count,
    output logic             update_pulse
);
    localparam logic [3:0]       GRADE_RST = 4'(GRADE_INIT);
    localparam logic [7:0]       THR_RST   = 8'(5 * (GRADE_INIT + 1));
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [31:0]      HI_LIM    = 32'(HI_MARK);
    localparam logic [31:0]      LO_LIM    = 32'(LO_MARK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_EVAL,
        S_COMMIT
    } state_t;

    function automatic logic [7:0] grade_to_thr(input logic [3:0] g);
        logic [7:0] g1;
        g1 = {4'd0, g} + 8'd1;
        return (g1 << 2) + g1;
    endfunction

    logic add_press, sub_press;

    frame_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_add (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_add_n),
        .press (add_press)
    );

    frame_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sub (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_sub_n),
        .press (sub_press)
    );

    state_t           state_q, state_d;
    logic             vs_q, vs_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] motion_count_q, motion_count_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       grade_q, grade_d;
    logic [7:0]       thr_q, thr_d;
    logic             update_pulse_q, update_pulse_d;

    logic vs_rise;
    logic over_hi, under_lo;

    assign vs_rise  = per_frame_vsync & ~vs_q;
    assign over_hi  = 32'(counter_q) > HI_LIM;
    assign under_lo = 32'(counter_q) < LO_LIM;

`ifndef FRAME_AUTO_THRESH_EN
    logic unused_auto;
    assign unused_auto = ^{auto_en, over_hi, under_lo};
`endif

    always_comb begin
        pending_d = pending_q;
        // Key requests take priority over the auto step when they coincide with EVAL.
        if (add_press || sub_press) begin
            if (add_press && !sub_press && pending_q != 4'd15)
                pending_d = pending_q + 4'd1;
            else if (sub_press && !add_press && pending_q != 4'd0)
                pending_d = pending_q - 4'd1;
        end
`ifdef FRAME_AUTO_THRESH_EN
        else if (state_q == S_EVAL && auto_en) begin
            if (over_hi && pending_q != 4'd15)
                pending_d = pending_q + 4'd1;
            else if (under_lo && pending_q != 4'd0)
                pending_d = pending_q - 4'd1;
        end
`endif
    end

    always_comb begin
        state_d        = state_q;
        vs_d           = per_frame_vsync;
        counter_d      = counter_q;
        motion_count_d = motion_count_q;
        grade_d        = grade_q;
        thr_d          = thr_q;
        update_pulse_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                counter_d = '0;
                if (vs_rise) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (per_frame_clken && per_img_motion && counter_q != CNT_MAX)
                    counter_d = counter_q + CNT_W'(1);
                if (vs_rise) state_d = S_EVAL;
            end
            S_EVAL: begin
                motion_count_d = counter_q;
                update_pulse_d = 1'b1;
                state_d        = S_COMMIT;
            end
            S_COMMIT: begin
                grade_d   = pending_q;
                thr_d     = grade_to_thr(pending_q);
                counter_d = '0;
                state_d   = S_ACTIVE;
            end
            default: begin
                state_d   = S_IDLE;
                counter_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            vs_q           <= 1'b0;
            counter_q      <= '0;
            motion_count_q <= '0;
            pending_q      <= GRADE_RST;
            grade_q        <= GRADE_RST;
            thr_q          <= THR_RST;
            update_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            vs_q           <= vs_d;
            counter_q      <= counter_d;
            motion_count_q <= motion_count_d;
            pending_q      <= pending_d;
            grade_q        <= grade_d;
            thr_q          <= thr_d;
            update_pulse_q <= update_pulse_d;
        end
    end

    assign frame_grade     = grade_q;
    assign frame_threshold = thr_q;
    assign motion_count    = motion_count_q;
    assign update_pulse    = update_pulse_q;
endmodule

// File: tb/tb_frame_threshold_ctrl.sv
// Directed bench for frame_threshold_ctrl with a scoreboard of expected commits.
module tb_frame_threshold_ctrl;
  localparam int CNT_W = 8;
  localparam int W = 4 + 8 + CNT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_add_n = 1'b1;
  logic key_sub_n = 1'b1;
  logic per_frame_vsync = 1'b0;
  logic per_frame_clken = 1'b0;
  logic per_img_motion = 1'b0;
  logic auto_en = 1'b0;
  logic [3:0] frame_grade;
  logic [7:0] frame_threshold;
  logic [CNT_W-1:0] motion_count;
  logic update_pulse;

  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  int model_grade = 2;
  bit started = 1'b0;

  frame_threshold_ctrl #(
    .DEBOUNCE_CYC(4), .CNT_W(CNT_W), .GRADE_INIT(2), .HI_MARK(100), .LO_MARK(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_add_n(key_add_n), .key_sub_n(key_sub_n),
    .per_frame_vsync(per_frame_vsync), .per_frame_clken(per_frame_clken),
    .per_img_motion(per_img_motion), .auto_en(auto_en),
    .frame_grade(frame_grade), .frame_threshold(frame_threshold),
    .motion_count(motion_count), .update_pulse(update_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int thr_of(input int g);
    return 5 * (g + 1);
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit add, input bit sub);
    @(posedge clk); #1;
    key_add_n = ~add;
    key_sub_n = ~sub;
    idle(10);
    key_add_n = 1'b1;
    key_sub_n = 1'b1;
    idle(10);
    if (add && !sub && model_grade < 15) model_grade++;
    else if (sub && !add && model_grade > 0) model_grade--;
  endtask

  task automatic pixels(input int n, input bit clken, input bit motion);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      per_frame_clken = clken;
      per_img_motion = motion;
    end
    @(posedge clk); #1;
    per_frame_clken = 1'b0;
    per_img_motion = 1'b0;
  endtask

  task automatic do_frame(input int n_pix);
    int cnt;
    if (n_pix > 0) pixels(n_pix, 1'b1, 1'b1);
    if (started) begin
      cnt = (n_pix > 255) ? 255 : n_pix;
`ifdef FRAME_AUTO_THRESH_EN
      if (auto_en) begin
        if (cnt > 100 && model_grade < 15) model_grade++;
        else if (cnt < 10 && model_grade > 0) model_grade--;
      end
`endif
      exp_q.push_back({4'(model_grade), 8'(thr_of(model_grade)), CNT_W'(cnt)});
    end
    started = 1'b1;
    per_frame_vsync = 1'b1;
    idle(4);
    per_frame_vsync = 1'b0;
    idle(4);
  endtask

  // scoreboard monitor: every update_pulse must match the oldest expected commit
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && update_pulse) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          check("unexpected_update_pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("commit_grade", int'(frame_grade), int'(e[W-1 -: 4]));
          check("commit_threshold", int'(frame_threshold), int'(e[CNT_W+7 -: 8]));
          check("commit_motion_count", int'(motion_count), int'(e[CNT_W-1:0]));
          check("update_pulse_one_cycle", int'(update_pulse), 0);
        end
      end
    end
  end

  initial begin
    idle(3);
    check("reset_grade", int'(frame_grade), 2);
    check("reset_threshold", int'(frame_threshold), 15);
    check("reset_motion_count", int'(motion_count), 0);
    check("reset_update_pulse", int'(update_pulse), 0);
    rst_n = 1'b1;
    idle(3);

    // three frames, no keys
    do_frame(0);
    do_frame(0);
    do_frame(0);

    // bounce then a real press, mid-frame
    key_add_n = 1'b0; idle(2);
    key_add_n = 1'b1; idle(3);
    key_add_n = 1'b0; idle(10);
    key_add_n = 1'b1; idle(10);
    model_grade = 3;
    check("grade_held_mid_frame", int'(frame_grade), 2);
    check("threshold_held_mid_frame", int'(frame_threshold), 15);
    do_frame(0);

    // saturation both ways, then simultaneous press
    for (int i = 0; i < 16; i++) press(1'b1, 1'b0);
    do_frame(0);
    for (int i = 0; i < 20; i++) press(1'b0, 1'b1);
    do_frame(0);
    press(1'b1, 1'b1);
    do_frame(0);

    // motion counter saturation and gating
    pixels(5, 1'b1, 1'b0);
    pixels(5, 1'b0, 1'b1);
    do_frame(300);
    do_frame(7);

    // auto grading (only moves the grade with the macro)
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    do_frame(0);
    auto_en = 1'b1;
    do_frame(150);
    do_frame(5);
    auto_en = 1'b0;

    // reset mid-frame with pending grade 5
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    pixels(6, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_grade", int'(frame_grade), 2);
    check("midreset_threshold", int'(frame_threshold), 15);
    check("midreset_motion_count", int'(motion_count), 0);
    check("midreset_update_pulse", int'(update_pulse), 0);
    model_grade = 2;
    started = 1'b0;
    check("midreset_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(2);
    do_frame(4);
    do_frame(9);

    idle(10);
    check("all_commits_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
